mem_arbiter_rr: RTL

Parametrised N-port arbiter between the L1 caches (I-cache, D-cache, and any additional line-granular requesters) and the single L2/memory port. It generalises the two-port I/D arbiter to NUM_PORTS requesters, adds a selectable round-robin or fixed-priority policy, and registers address and write data at grant. Each transaction is one full cache line, read or write. A grant is held until the downstream response arrives.

---
 rtl/mem_arbiter_rr.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//
// Arbiter between NUM_PORTS line-granular requesters (port 0 = I-cache) and a
// single L2/memory port. Each transaction moves one full cache line. The winner
// is chosen by round-robin or fixed priority. Its address and write line are
// captured at grant, and the grant is held until the downstream completes.
// After completion there is one turnaround cycle (DONE), so the served cache
// can drop its request before the next arbitration.
//
// Ports
//   clk, reset_n      : clock (rising edge) and asynchronous active-low reset
//   req_read/_write   : per-port level requests, held until that port's req_resp
//   req_address       : per-port line address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata         : per-port write line, port i at [i*LINE_WIDTH +: LINE_WIDTH]
//   req_rdata         : downstream read line broadcast to every port
//   req_resp          : one-hot completion pulse, coincident with mem_resp
//   mem_address/wdata : registered downstream address and write line
//   mem_read/write    : downstream request, held until mem_resp
//   mem_rdata/resp    : downstream read line and single-cycle completion
//   grant_id          : index of the current or most recent grant
//   busy              : high while a transaction is outstanding or turning around
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 256,
    parameter int PRIORITY_MODE = 0,
    localparam int IDW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
    output logic [LINE_WIDTH-1:0]            req_rdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [LINE_WIDTH-1:0]            mem_wdata,
    output logic                             mem_read,
    output logic                             mem_write,
    input  logic [LINE_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_resp,
    output logic [IDW-1:0]                   grant_id,
    output logic                             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic [IDW-1:0]        grant_id_q,   grant_id_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic                  mem_read_q,   mem_read_d;
    logic                  mem_write_q,  mem_write_d;
    logic                  busy_q,       busy_d;

    logic [NUM_PORTS-1:0]  req_any_s;
    logic                  req_valid_s;
    logic [IDW-1:0]        rr_start_s;
    logic [IDW-1:0]        rr_win_s;
    logic [IDW-1:0]        fp_win_s;
    logic [IDW-1:0]        winner_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [LINE_WIDTH-1:0] sel_wdata_s;
    logic                  sel_write_s;

    // Request summary and the round-robin search start (last_grant + 1, wrapped).
    always_comb begin
        req_any_s   = req_read | req_write;
        req_valid_s = |req_any_s;
        if (last_grant_q == IDW'(NUM_PORTS - 1)) begin
            rr_start_s = {IDW{1'b0}};
        end else begin
            rr_start_s = last_grant_q + IDW'(1);
        end
    end

    // Round-robin winner: the port at rotated offset j from the start is
    // port (start + j) mod N, so start == (i - j) mod N picks out port i. Scanning
    // j downwards lets the smallest offset overwrite larger ones.
    always_comb begin
        rr_win_s = {IDW{1'b0}};
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                rr_win_s = (req_any_s[i] &&
                            (rr_start_s == IDW'((i - j + NUM_PORTS) % NUM_PORTS)))
                           ? IDW'(i) : rr_win_s;
            end
        end
    end

    // Fixed-priority winner: scanning downwards leaves the lowest requester.
    always_comb begin
        fp_win_s = {IDW{1'b0}};
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            fp_win_s = req_any_s[i] ? IDW'(i) : fp_win_s;
        end
    end

    // Policy select.
    always_comb begin
        if (PRIORITY_MODE == 1) begin
            winner_s = fp_win_s;
        end else begin
            winner_s = rr_win_s;
        end
    end

    // Mux the winner's address, write line and op; read+write together is a write.
    always_comb begin
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_wdata_s = {LINE_WIDTH{1'b0}};
        sel_write_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_addr_s  = (winner_s == IDW'(i)) ? req_address[i*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
            sel_wdata_s = (winner_s == IDW'(i)) ? req_wdata[i*LINE_WIDTH +: LINE_WIDTH]   : sel_wdata_s;
            sel_write_s = (winner_s == IDW'(i)) ? req_write[i]                            : sel_write_s;
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and its captured fields.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_s) begin
                    state_d      = ST_BUSY;
                    last_grant_d = winner_s;
                    grant_id_d   = winner_s;
                    mem_addr_d   = sel_addr_s;
                    mem_wdata_d  = sel_wdata_s;
                    mem_write_d  = sel_write_s;
                    mem_read_d   = ~sel_write_s;
                    busy_d       = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Requests are deliberately not looked at here; only mem_resp ends it.
                if (mem_resp) begin
                    state_d     = ST_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State registers; last_grant resets to the top port so port 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_PORTS - 1);
            grant_id_q   <= {IDW{1'b0}};
            mem_addr_q   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q  <= {LINE_WIDTH{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            busy_q       <= busy_d;
        end
    end

    // Completion is passed straight through to the granted port in the same cycle.
    always_comb begin
        req_resp = {NUM_PORTS{1'b0}};
        if ((state_q == ST_BUSY) && mem_resp) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_resp[i] = (grant_id_q == IDW'(i));
            end
        end else begin
            req_resp = {NUM_PORTS{1'b0}};
        end
    end

    assign req_rdata   = mem_rdata;
    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;

    mem_arbiter_rr_chk #(
        .NUM_PORTS (NUM_PORTS)
    ) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_resp  (req_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_resp  (mem_resp),
        .busy      (busy)
    );

endmodule

// -----------------------------------------------------------------------------
// mem_arbiter_rr_chk
//
// Protocol properties of the arbiter outputs: at most one completion at a time,
// completions only alongside mem_resp, never read and write together, and no
// downstream request outside a busy period.
// Ports: clk, reset_n, req_resp, mem_read, mem_write, mem_resp, busy (all inputs).
// -----------------------------------------------------------------------------
module mem_arbiter_rr_chk #(
    parameter int NUM_PORTS = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    input logic [NUM_PORTS-1:0] req_resp,
    input logic                 mem_read,
    input logic                 mem_write,
    input logic                 mem_resp,
    input logic                 busy
);

    a_resp_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_resp));

    a_resp_with_mem: assert property (@(posedge clk) disable iff (!reset_n)
        (req_resp != {NUM_PORTS{1'b0}}) |-> mem_resp);

    a_no_rw: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_read && mem_write));

    a_req_busy: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_read || mem_write) |-> busy);

endmodule
